// File: rtl/riscv_wbarb.sv
// Writeback arbiter: merges pipeline writeback with buffered long-latency
// results onto the single register-file write port.
module riscv_wbarb #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            i_riscv_wbarb_clk,
  input  logic            i_riscv_wbarb_rst,
  input  logic            i_riscv_wbarb_pipe_regwrite,
  input  logic [4:0]      i_riscv_wbarb_pipe_rdaddr,
  input  logic [XLEN-1:0] i_riscv_wbarb_pipe_rddata,
  input  logic            i_riscv_wbarb_llu_valid,
  input  logic [4:0]      i_riscv_wbarb_llu_rdaddr,
  input  logic [XLEN-1:0] i_riscv_wbarb_llu_rddata,
  output logic            o_riscv_wbarb_llu_ready,
  output logic            o_riscv_wbarb_regwrite,
  output logic [4:0]      o_riscv_wbarb_rdaddr,
  output logic [XLEN-1:0] o_riscv_wbarb_rddata,
  output logic [31:0]     o_riscv_wbarb_pending,
  output logic            o_riscv_wbarb_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [4:0]       fifo_rd_d   [DEPTH];
  logic [XLEN-1:0]  fifo_data_q [DEPTH];
  logic [XLEN-1:0]  fifo_data_d [DEPTH];
  logic [CW-1:0]    starve_q, starve_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rdaddr_q, rdaddr_d;
  logic [XLEN-1:0]  rddata_q, rddata_d;

  logic             empty, full, pipe_occ, pop, bypass, push;
  logic [AW:0]      count;
  logic [AW-1:0]    idx;
  logic [31:0]      pending;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pipe_occ = i_riscv_wbarb_pipe_regwrite && (i_riscv_wbarb_pipe_rdaddr != '0);
  assign pop      = !pipe_occ && !empty;
  // Bypass only when nothing is buffered, so FIFO order is never violated.
  assign bypass   = !pipe_occ && empty && i_riscv_wbarb_llu_valid &&
                    (i_riscv_wbarb_llu_rdaddr != '0);
  assign push     = i_riscv_wbarb_llu_valid && !full &&
                    (i_riscv_wbarb_llu_rdaddr != '0) && !bypass;

  always_comb begin
    pending = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q[AW-1:0] + AW'(k);
      if (k < 32'(count)) pending[fifo_rd_q[idx]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_comb begin
    regwrite_d  = 1'b0;
    rdaddr_d    = rdaddr_q;
    rddata_d    = rddata_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    starve_d    = starve_q;

    if (pipe_occ) begin
      regwrite_d = 1'b1;
      rdaddr_d   = i_riscv_wbarb_pipe_rdaddr;
      rddata_d   = i_riscv_wbarb_pipe_rddata;
    end else if (pop) begin
      regwrite_d = 1'b1;
      rdaddr_d   = fifo_rd_q[rd_ptr_q[AW-1:0]];
      rddata_d   = fifo_data_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end else if (bypass) begin
      regwrite_d = 1'b1;
      rdaddr_d   = i_riscv_wbarb_llu_rdaddr;
      rddata_d   = i_riscv_wbarb_llu_rddata;
    end

    if (push) begin
      fifo_rd_d[wr_ptr_q[AW-1:0]]   = i_riscv_wbarb_llu_rdaddr;
      fifo_data_d[wr_ptr_q[AW-1:0]] = i_riscv_wbarb_llu_rddata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (empty || pop) starve_d = '0;
    else if (pipe_occ && (starve_q != CW'(STARVE_LIMIT))) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_riscv_wbarb_clk or posedge i_riscv_wbarb_rst) begin
    if (i_riscv_wbarb_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      rdaddr_q   <= '0;
      rddata_q   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        fifo_rd_q[k]   <= '0;
        fifo_data_q[k] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      starve_q    <= starve_d;
      regwrite_q  <= regwrite_d;
      rdaddr_q    <= rdaddr_d;
      rddata_q    <= rddata_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign o_riscv_wbarb_llu_ready = !full;
  assign o_riscv_wbarb_regwrite  = regwrite_q;
  assign o_riscv_wbarb_rdaddr    = rdaddr_q;
  assign o_riscv_wbarb_rddata    = rddata_q;
  assign o_riscv_wbarb_pending   = pending;
  assign o_riscv_wbarb_stall     = (starve_q == CW'(STARVE_LIMIT));

endmodule

// File: tb/tb_riscv_wbarb.sv
// Scoreboard bench for riscv_wbarb: expected writes are queued as stimulus is
// driven and compared when the registered write port presents them.
module tb_riscv_wbarb;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIM   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pipe_we = 1'b0;
  logic [4:0]      pipe_rd = '0;
  logic [XLEN-1:0] pipe_data = '0;
  logic            llu_v = 1'b0;
  logic [4:0]      llu_rd = '0;
  logic [XLEN-1:0] llu_data = '0;
  logic            llu_ready, regwrite, stall;
  logic [4:0]      rdaddr;
  logic [XLEN-1:0] rddata;
  logic [31:0]     pending;

  riscv_wbarb #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .i_riscv_wbarb_clk           (clk),
    .i_riscv_wbarb_rst           (rst),
    .i_riscv_wbarb_pipe_regwrite (pipe_we),
    .i_riscv_wbarb_pipe_rdaddr   (pipe_rd),
    .i_riscv_wbarb_pipe_rddata   (pipe_data),
    .i_riscv_wbarb_llu_valid     (llu_v),
    .i_riscv_wbarb_llu_rdaddr    (llu_rd),
    .i_riscv_wbarb_llu_rddata    (llu_data),
    .o_riscv_wbarb_llu_ready     (llu_ready),
    .o_riscv_wbarb_regwrite      (regwrite),
    .o_riscv_wbarb_rdaddr        (rdaddr),
    .o_riscv_wbarb_rddata        (rddata),
    .o_riscv_wbarb_pending       (pending),
    .o_riscv_wbarb_stall         (stall)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [4:0] rd; logic [63:0] data; } wr_t;
  typedef struct { logic [4:0] rd; logic [63:0] data; } ent_t;

  wr_t         exp_q[$];
  ent_t        mq[$];
  int          scnt = 0;
  logic [4:0]  last_rd = '0;
  logic [63:0] last_data = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  // Called at posedge+1; drives one cycle of stimulus and checks its result.
  task automatic step(input logic pw, input logic [4:0] pa, input logic [63:0] pd,
                      input logic lv, input logic [4:0] la, input logic [63:0] ld);
    wr_t  e;
    ent_t h;
    logic occ, byp, rdy, was_empty;
    check_eq("llu_ready", llu_ready, (mq.size() < DEPTH));
    check_eq("pending", pending, model_pending());
    check_eq("stall", stall, (scnt == LIM));
    occ = pw && (pa != 0);
    rdy = (mq.size() < DEPTH);
    was_empty = (mq.size() == 0);
    byp = 1'b0;
    if (occ) e = '{1'b1, pa, pd};
    else if (!was_empty) begin
      h = mq.pop_front();
      e = '{1'b1, h.rd, h.data};
    end else if (lv && la != 0) begin
      byp = 1'b1;
      e = '{1'b1, la, ld};
    end else e = '{1'b0, last_rd, last_data};
    if (e.we) begin last_rd = e.rd; last_data = e.data; end
    if (lv && rdy && la != 0 && !byp) mq.push_back('{la, ld});
    if (was_empty || !occ) scnt = 0;
    else if (scnt < LIM) scnt++;
    exp_q.push_back(e);
    pipe_we = pw; pipe_rd = pa; pipe_data = pd;
    llu_v = lv; llu_rd = la; llu_data = ld;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check_eq("regwrite", regwrite, e.we);
    check_eq("rdaddr", rdaddr, e.rd);
    check_eq("rddata", rddata, e.data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pipe_we = 0; llu_v = 0;
    #1;
    check_eq("rst_pending", pending, 32'h0);
    check_eq("rst_ready", llu_ready, 1'b1);
    check_eq("rst_regwrite", regwrite, 1'b0);
    check_eq("rst_rdaddr", rdaddr, 5'd0);
    check_eq("rst_rddata", rddata, 64'h0);
    check_eq("rst_stall", stall, 1'b0);
    mq.delete(); exp_q.delete();
    scnt = 0; last_rd = '0; last_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    idle(10);

    // Single pipe write, one-cycle pulse, then x0 ignored.
    step(1, 5, 64'hDEAD_BEEF, 0, 0, 0);
    check_eq("x5_we", regwrite, 1'b1);
    check_eq("x5_data", rddata, 64'hDEAD_BEEF);
    idle(1);
    check_eq("x5_pulse", regwrite, 1'b0);
    step(1, 0, 64'h55, 0, 0, 0);
    check_eq("x0_nowrite", regwrite, 1'b0);

    // Bypass with idle pipe and empty FIFO.
    step(0, 0, 0, 1, 7, 64'h1234);
    check_eq("byp_rd", rdaddr, 5'd7);
    check_eq("byp_pend", pending, 32'h0);
    idle(1);

    // Buffer two results under a busy pipe, then drain in order.
    step(1, 1, 64'hA1, 1, 7, 64'h1);
    step(1, 2, 64'hA2, 1, 9, 64'h2);
    check_eq("pend_x7x9", pending, 32'h0000_0280);
    check_eq("full_ready", llu_ready, 1'b0);
    step(1, 3, 64'hA3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("drain1_rd", rdaddr, 5'd7);
    step(0, 0, 0, 0, 0, 0);
    check_eq("drain2_rd", rdaddr, 5'd9);
    check_eq("drain_pend", pending, 32'h0);
    idle(1);

    // Starvation: one buffered entry under a continuously busy pipe.
    step(1, 4, 64'hB0, 1, 11, 64'hCAFE);
    for (int i = 0; i < 3; i++) step(1, 4, 64'hB1 + i, 0, 0, 0);
    check_eq("stall_early", stall, 1'b0);
    step(1, 4, 64'hB5, 0, 0, 0);
    check_eq("stall_rise", stall, 1'b1);
    step(1, 6, 64'hB6, 0, 0, 0);
    check_eq("stall_hold", stall, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("stall_pop_rd", rdaddr, 5'd11);
    check_eq("stall_drop", stall, 1'b0);
    idle(1);

    // Fill FIFO, then reset: nothing buffered may ever be written.
    step(1, 1, 64'hC1, 1, 3, 64'h33);
    step(1, 1, 64'hC2, 1, 4, 64'h44);
    check_eq("prerst_pend", pending, 32'h0000_0018);
    do_reset();
    idle(4);

    // Random traffic; pipe honours the stall bubble.
    for (int i = 0; i < 300; i++) begin
      logic pw;
      pw = (scnt == LIM) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(pw, 5'($urandom_range(0, 31)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
